// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, default oversample ratio and the even-parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int DEFAULT_OVERSAMPLE = 16;

  // Operands narrower than 64 bits are zero-extended by the caller, which leaves the XOR unchanged.
  function automatic logic even_parity(input logic [63:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx line, plus a third flop for falling-edge detection.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic sync_d_q;

  // All flops reset to the idle-high level so that reset release never looks like a start edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q   <= 1'b1;
      sync_q   <= 1'b1;
      sync_d_q <= 1'b1;
    end else begin
      meta_q   <= rx;
      sync_q   <= meta_q;
      sync_d_q <= sync_q;
    end
  end

  assign rx_s = sync_q;
  assign fall = sync_d_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled start/data/even-parity/stop recovery with a valid/ready word output.
// Optional build macro UART_RX_MAJORITY_EN selects 2-of-3 majority sampling around each bit centre.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  baud_x16_en,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun_err,
  output logic                  rx_busy
);

  localparam int OSW = $clog2(OVERSAMPLE);
  localparam int BW  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
`ifdef UART_RX_MAJORITY_EN
  localparam int START_LIM = OVERSAMPLE / 2;
`else
  localparam int START_LIM = OVERSAMPLE / 2 - 1;
`endif

  uart_state_e           state_q, state_d;
  logic [OSW-1:0]        os_cnt_q, os_cnt_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  p_bit_q, p_bit_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  perr_q, perr_d;
  logic                  ferr_q, ferr_d;
  logic                  oerr_q, oerr_d;

  logic           rx_s;
  logic           fall;
  logic [OSW-1:0] lim;
  logic           at_lim;
  logic           bit_val;

  uart_rx_sync u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .rx   (rx),
    .rx_s (rx_s),
    .fall (fall)
  );

  // The start bit is decided half a bit in; every later bit a full bit period after the previous decision.
  assign lim    = (state_q == ST_START) ? OSW'(START_LIM) : OSW'(OVERSAMPLE - 1);
  assign at_lim = baud_x16_en && (os_cnt_q == lim);

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] maj_q, maj_d;

  always_comb begin
    maj_d = maj_q;
    if (baud_x16_en && (state_q != ST_IDLE)) begin
      if (os_cnt_q == lim - OSW'(2)) maj_d[0] = rx_s;
      if (os_cnt_q == lim - OSW'(1)) maj_d[1] = rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) maj_q <= 2'b11;
    else        maj_q <= maj_d;
  end

  assign bit_val = (maj_q[0] & maj_q[1]) | (rx_s & (maj_q[0] | maj_q[1]));
`else
  assign bit_val = rx_s;
`endif

  always_comb begin
    state_d   = state_q;
    os_cnt_d  = os_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    p_bit_d   = p_bit_q;
    data_d    = data_q;
    valid_d   = valid_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    oerr_d    = oerr_q;

    if (valid_q && rx_ready) valid_d = 1'b0;
    if (baud_x16_en && (state_q != ST_IDLE)) os_cnt_d = at_lim ? '0 : os_cnt_q + 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (fall) begin
          os_cnt_d = '0;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        bit_cnt_d = '0;
        if (at_lim) state_d = bit_val ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (at_lim) begin
          shreg_d   = {bit_val, shreg_q[DATA_WIDTH-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BW'(DATA_WIDTH - 1)) state_d = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (at_lim) begin
          p_bit_d = bit_val;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        // A completion coinciding with an accept replaces the consumed word without flagging overrun.
        if (at_lim) begin
          data_d  = shreg_q;
          perr_d  = p_bit_q != even_parity(64'(shreg_q));
          ferr_d  = ~bit_val;
          oerr_d  = valid_q & ~rx_ready;
          valid_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      os_cnt_q  <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      p_bit_q   <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      oerr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      os_cnt_q  <= os_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      p_bit_q   <= p_bit_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      oerr_q    <= oerr_d;
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign parity_err  = perr_q;
  assign frame_err   = ferr_q;
  assign overrun_err = oerr_q;
  assign rx_busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: OVERSAMPLE=16 with a baud tick every 4 clk, so one bit lasts 64 clk.
module tb_uart_rx;

  localparam int BITCLK = 64;
  localparam int FRAMECLK = 11 * BITCLK;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       baud = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       overrun_err;
  logic       rx_busy;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   rises = 0;
  int   rise_cyc = 0;
  int   last_start = 0;
  int   pulse_at = -1;
  logic rise_tick = 1'b0;
  logic vld_prev = 1'b0;

  uart_rx #(.DATA_WIDTH(8), .OVERSAMPLE(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .baud_x16_en(baud),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun_err(overrun_err),
    .rx_busy    (rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(negedge clk);
      baud = (cyc % 4 == 0);
    end
  end

  // Records each rx_valid rising edge and whether it was registered on a baud-tick edge.
  always @(posedge clk) begin
    #1;
    if (rx_valid === 1'b1 && vld_prev !== 1'b1) begin
      rises++;
      rise_cyc = cyc;
      rise_tick = baud;
    end
    vld_prev = rx_valid;
  end

  initial begin
    #(80000 * 10);
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    repeat (BITCLK) begin
      @(negedge clk);
      if (pulse_at >= 0) rx_ready = (cyc == pulse_at);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop);
    last_start = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit((^d) ^ bad_par);
    send_bit(stop);
  endtask

  task automatic accept();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic align();
    do @(negedge clk); while (cyc % 4 != 1);
  endtask

  initial begin
    int r0;
    int s11;
    int offset;

    repeat (3) @(negedge clk);
    check("rst_valid", rx_valid, 1'b0);
    check("rst_data", rx_data, 8'h00);
    check("rst_errs", {parity_err, frame_err, overrun_err}, 3'b000);
    check("rst_busy", rx_busy, 1'b0);
    rst_n = 1'b1;
    repeat (2) send_bit(1'b1);

    // 1: clean frame
    send_frame(8'hA5, 1'b0, 1'b1);
    check("t1_data", rx_data, 8'hA5);
    check("t1_valid", rx_valid, 1'b1);
    check("t1_errs", {parity_err, frame_err, overrun_err}, 3'b000);
    check("t1_rises", rises, 1);
    check("t1_rise_on_tick", rise_tick, 1'b1);
    check("t1_busy", rx_busy, 1'b0);
    accept();
    check("t1_accepted", rx_valid, 1'b0);
    send_bit(1'b1);

    // 2: parity error
    send_frame(8'h3C, 1'b1, 1'b1);
    check("t2_data", rx_data, 8'h3C);
    check("t2_perr", parity_err, 1'b1);
    check("t2_ferr", frame_err, 1'b0);
    accept();
    send_bit(1'b1);

    // 3: frame error followed by a 40-bit break
    r0 = rises;
    send_frame(8'h00, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (40 * BITCLK) @(negedge clk);
    check("t3_one_word", rises, r0 + 1);
    check("t3_data", rx_data, 8'h00);
    check("t3_ferr", frame_err, 1'b1);
    check("t3_perr", parity_err, 1'b0);
    check("t3_busy", rx_busy, 1'b0);
    accept();
    repeat (2) send_bit(1'b1);
    send_frame(8'h55, 1'b0, 1'b1);
    check("t3_next_data", rx_data, 8'h55);
    check("t3_next_valid", rx_valid, 1'b1);
    check("t3_next_errs", {parity_err, frame_err, overrun_err}, 3'b000);
    accept();
    send_bit(1'b1);

    // 4: 6-tick glitch is a false start
    r0 = rises;
    rx = 1'b0;
    repeat (24) @(negedge clk);
    rx = 1'b1;
    check("t4_busy_start", rx_busy, 1'b1);
    repeat (2 * BITCLK) @(negedge clk);
    check("t4_no_word", rises, r0);
    check("t4_valid", rx_valid, 1'b0);
    check("t4_busy_end", rx_busy, 1'b0);
`ifdef UART_RX_MAJORITY_EN
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (BITCLK - 34) @(negedge clk);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    check("t4_maj_data", rx_data, 8'hFF);
    check("t4_maj_perr", parity_err, 1'b0);
    accept();
    send_bit(1'b1);
`endif

    // 5a: back-to-back with no accept -> overrun
    align();
    send_frame(8'h11, 1'b0, 1'b1);
    s11 = last_start;
    send_frame(8'h22, 1'b0, 1'b1);
    offset = rise_cyc - s11;
    check("t5a_data", rx_data, 8'h22);
    check("t5a_valid", rx_valid, 1'b1);
    check("t5a_oerr", overrun_err, 1'b1);
    accept();
    send_bit(1'b1);

    // 5b: accept exactly on the 0x22 completion cycle -> no overrun
    align();
    pulse_at = cyc + FRAMECLK + offset - 1;
    send_frame(8'h11, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1);
    pulse_at = -1;
    rx_ready = 1'b0;
    check("t5b_data", rx_data, 8'h22);
    check("t5b_valid", rx_valid, 1'b1);
    check("t5b_oerr", overrun_err, 1'b0);
    send_bit(1'b1);

    // 6: reset in the middle of the data bits of 0x5A
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rx = 1'b1;
    repeat (32) @(negedge clk);
    check("t6_busy_pre", rx_busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t6_valid", rx_valid, 1'b0);
    check("t6_data", rx_data, 8'h00);
    check("t6_errs", {parity_err, frame_err, overrun_err}, 3'b000);
    check("t6_busy", rx_busy, 1'b0);
    r0 = rises;
    repeat (10 * BITCLK) @(negedge clk);
    check("t6_no_word", rises, r0);
    send_frame(8'h5A, 1'b0, 1'b1);
    check("t6_next_data", rx_data, 8'h5A);
    check("t6_next_valid", rx_valid, 1'b1);
    check("t6_next_errs", {parity_err, frame_err, overrun_err}, 3'b000);
    accept();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
